// File: rtl/register_writeback_pkg.sv
// register_writeback_pkg: shared entry layout, constants and sizing helper for the writeback queue.
package register_writeback_pkg;
    localparam int DEFAULT_DEPTH      = 4;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 5;
    localparam int ZERO_REGISTER      = 0;

    typedef struct packed {
        logic [DEFAULT_ADDR_WIDTH-1:0] destiny;
        logic [DEFAULT_DATA_WIDTH-1:0] data;
    } entry_t;

    function automatic int pointer_width(input int depth);
        return $clog2(depth);
    endfunction
endpackage

// File: rtl/writeback_fifo.sv
// writeback_fifo: circular result buffer with wrap-bit pointers, occupancy count and synchronous flush.
module writeback_fifo
    import register_writeback_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = DEFAULT_ADDR_WIDTH + DEFAULT_DATA_WIDTH,
    localparam int PW   = pointer_width(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_entry,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [PW:0]      count,
    output logic [PW-1:0]    read_index,
    output logic [WIDTH-1:0] entries [DEPTH]
);
    logic [PW:0] read_pointer;
    logic [PW:0] write_pointer;

    assign read_index = read_pointer[PW-1:0];
    assign head       = entries[read_index];
    assign empty      = read_pointer == write_pointer;
    assign full       = read_pointer[PW-1:0] == write_pointer[PW-1:0] && read_pointer[PW] != write_pointer[PW];
    assign count      = write_pointer - read_pointer;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            read_pointer  <= '0;
            write_pointer <= '0;
        end else if (flush) begin
            read_pointer  <= '0;
            write_pointer <= '0;
        end else begin
            if (push) write_pointer <= write_pointer + (PW+1)'(1);
            if (pop)  read_pointer  <= read_pointer + (PW+1)'(1);
        end
    end

    // Storage needs no reset: occupancy is governed entirely by the pointers.
    always_ff @(posedge clock) begin
        if (push && !flush) entries[write_pointer[PW-1:0]] <= push_entry;
    end
endmodule

// File: rtl/register_writeback.sv
// register_writeback: in-order result queue draining onto the register bank write port.
// Optional bypass scan enabled by REGISTER_WRITEBACK_BYPASS_EN.
module register_writeback
    import register_writeback_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    localparam int PW        = pointer_width(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  result_valid,
    output logic                  result_ready,
    input  logic [ADDR_WIDTH-1:0] result_destiny,
    input  logic [DATA_WIDTH-1:0] result_data,
    input  logic                  write_hold,
    input  logic                  flush,
    output logic                  write_enabled,
    output logic [ADDR_WIDTH-1:0] register_destiny,
    output logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] register_source1,
    input  logic [ADDR_WIDTH-1:0] register_source2,
    output logic                  bypass_hit1,
    output logic                  bypass_hit2,
    output logic [DATA_WIDTH-1:0] bypass_data1,
    output logic [DATA_WIDTH-1:0] bypass_data2,
    output logic [PW:0]           pending_count
);
    localparam int EW = ADDR_WIDTH + DATA_WIDTH;

    logic          full;
    logic          empty;
    logic          push;
    logic [EW-1:0] head;
    logic [PW-1:0] read_index;
    logic [EW-1:0] entries [DEPTH];

    // Writes to register 0 complete the handshake but are dropped here.
    assign result_ready     = !full;
    assign push             = result_valid && result_ready && !flush && result_destiny != ADDR_WIDTH'(ZERO_REGISTER);
    assign write_enabled    = !empty && !write_hold && !flush;
    assign register_destiny = empty ? '0 : head[DATA_WIDTH +: ADDR_WIDTH];
    assign write_data       = empty ? '0 : head[DATA_WIDTH-1:0];

    writeback_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (push),
        .pop        (write_enabled),
        .flush      (flush),
        .push_entry ({result_destiny, result_data}),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .count      (pending_count),
        .read_index (read_index),
        .entries    (entries)
    );

`ifdef REGISTER_WRITEBACK_BYPASS_EN
    logic [EW-1:0] slot;

    // Walk oldest to newest so the last match (closest to the tail) wins.
    always_comb begin
        bypass_hit1  = 1'b0;
        bypass_hit2  = 1'b0;
        bypass_data1 = '0;
        bypass_data2 = '0;
        slot         = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = entries[read_index + PW'(k)];
            if ((PW+1)'(k) < pending_count && register_source1 != ADDR_WIDTH'(ZERO_REGISTER)
                && slot[DATA_WIDTH +: ADDR_WIDTH] == register_source1) begin
                bypass_hit1  = 1'b1;
                bypass_data1 = slot[DATA_WIDTH-1:0];
            end
            if ((PW+1)'(k) < pending_count && register_source2 != ADDR_WIDTH'(ZERO_REGISTER)
                && slot[DATA_WIDTH +: ADDR_WIDTH] == register_source2) begin
                bypass_hit2  = 1'b1;
                bypass_data2 = slot[DATA_WIDTH-1:0];
            end
        end
    end
`else
    logic unused_bypass;

    assign bypass_hit1  = 1'b0;
    assign bypass_hit2  = 1'b0;
    assign bypass_data1 = '0;
    assign bypass_data2 = '0;

    always_comb begin
        unused_bypass = ^{register_source1, register_source2, read_index};
        for (int k = 0; k < DEPTH; k++) unused_bypass = unused_bypass ^ (^entries[k]);
    end
`endif
endmodule

// File: tb/tb_register_writeback.sv
// tb_register_writeback: directed self-checking bench for register_writeback (DEPTH=4).
module tb_register_writeback;
    localparam bit BP =
`ifdef REGISTER_WRITEBACK_BYPASS_EN
        1'b1;
`else
        1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        result_valid = 1'b0;
    logic        result_ready;
    logic [4:0]  result_destiny = '0;
    logic [31:0] result_data = '0;
    logic        write_hold = 1'b0;
    logic        flush = 1'b0;
    logic        write_enabled;
    logic [4:0]  register_destiny;
    logic [31:0] write_data;
    logic [4:0]  register_source1 = '0;
    logic [4:0]  register_source2 = '0;
    logic        bypass_hit1, bypass_hit2;
    logic [31:0] bypass_data1, bypass_data2;
    logic [2:0]  pending_count;

    int vectors = 0;
    int miscompares = 0;

    register_writeback #(.DEPTH(4), .DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .result_valid     (result_valid),
        .result_ready     (result_ready),
        .result_destiny   (result_destiny),
        .result_data      (result_data),
        .write_hold       (write_hold),
        .flush            (flush),
        .write_enabled    (write_enabled),
        .register_destiny (register_destiny),
        .write_data       (write_data),
        .register_source1 (register_source1),
        .register_source2 (register_source2),
        .bypass_hit1      (bypass_hit1),
        .bypass_hit2      (bypass_hit2),
        .bypass_data1     (bypass_data1),
        .bypass_data2     (bypass_data2),
        .pending_count    (pending_count)
    );

    always #5 clock = ~clock;

    task automatic step(input logic v, input logic [4:0] d, input logic [31:0] x, input logic h, input logic f);
        @(negedge clock);
        result_valid = v;
        result_destiny = d;
        result_data = x;
        write_hold = h;
        flush = f;
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        vectors++;
        if (pending_count !== 3'd0 || write_enabled !== 1'b0 || register_destiny !== 5'd0 || write_data !== 32'd0
            || result_ready !== 1'b1 || bypass_hit1 !== 1'b0 || bypass_hit2 !== 1'b0
            || bypass_data1 !== 32'd0 || bypass_data2 !== 32'd0) begin
            miscompares++;
            $display("FAIL reset: cnt=%0d we=%b dst=%0d data=%h rdy=%b hit=%b%b, required cnt=0 we=0 dst=0 data=0 rdy=1 hit=00",
                     pending_count, write_enabled, register_destiny, write_data, result_ready, bypass_hit1, bypass_hit2);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        step(1, 5, 32'hDEADBEEF, 0, 0);
        vectors++;
        if (write_enabled !== 1'b0 || result_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL single_pre: we=%b rdy=%b, required we=0 rdy=1", write_enabled, result_ready);
        end
        step(0, 0, 0, 0, 0);
        vectors++;
        if (write_enabled !== 1'b1 || register_destiny !== 5'd5 || write_data !== 32'hDEADBEEF || pending_count !== 3'd1) begin
            miscompares++;
            $display("FAIL single_write: we=%b dst=%0d data=%h cnt=%0d, required we=1 dst=5 data=deadbeef cnt=1",
                     write_enabled, register_destiny, write_data, pending_count);
        end
        step(0, 0, 0, 0, 0);
        vectors++;
        if (write_enabled !== 1'b0 || pending_count !== 3'd0 || register_destiny !== 5'd0 || write_data !== 32'd0) begin
            miscompares++;
            $display("FAIL single_empty: we=%b cnt=%0d dst=%0d data=%h, required all 0",
                     write_enabled, pending_count, register_destiny, write_data);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 4; i++) begin
            step(1, 5'(i), 32'h100 + 32'(i), 1, 0);
            vectors++;
            if (result_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL fill_ready%0d: rdy=%b, required 1", i, result_ready);
            end
        end
        step(1, 9, 32'h999, 1, 0);
        vectors++;
        if (pending_count !== 3'd4 || result_ready !== 1'b0 || write_enabled !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_full: cnt=%0d rdy=%b we=%b, required cnt=4 rdy=0 we=0", pending_count, result_ready, write_enabled);
        end
        step(0, 0, 0, 1, 0);
        vectors++;
        if (pending_count !== 3'd4) begin
            miscompares++;
            $display("FAIL fill_reject: cnt=%0d, required 4", pending_count);
        end
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 0, 0, 0);
            vectors++;
            if (write_enabled !== 1'b1 || register_destiny !== 5'(i) || write_data !== 32'h100 + 32'(i) || pending_count !== 3'(5 - i)) begin
                miscompares++;
                $display("FAIL fill_drain%0d: we=%b dst=%0d data=%h cnt=%0d, required we=1 dst=%0d data=%h cnt=%0d",
                         i, write_enabled, register_destiny, write_data, pending_count, i, 32'h100 + 32'(i), 5 - i);
            end
        end
        step(0, 0, 0, 0, 0);
        vectors++;
        if (pending_count !== 3'd0 || write_enabled !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_done: cnt=%0d we=%b, required 0 0", pending_count, write_enabled);
        end
    endtask

    task automatic test_zero_destiny();
        step(1, 0, 32'h1234, 0, 0);
        vectors++;
        if (result_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_ready: rdy=%b, required 1", result_ready);
        end
        step(0, 0, 0, 0, 0);
        vectors++;
        if (pending_count !== 3'd0 || write_enabled !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_drop: cnt=%0d we=%b, required 0 0", pending_count, write_enabled);
        end
    endtask

    task automatic test_bypass();
        step(1, 7, 32'h11, 1, 0);
        step(1, 7, 32'h22, 1, 0);
        step(1, 3, 32'h33, 1, 0);
        register_source1 = 5'd7;
        register_source2 = 5'd0;
        step(0, 0, 0, 1, 0);
        vectors++;
        if (bypass_hit1 !== BP || bypass_data1 !== (BP ? 32'h22 : 32'h0) || bypass_hit2 !== 1'b0 || bypass_data2 !== 32'h0) begin
            miscompares++;
            $display("FAIL bypass_newest: hit1=%b d1=%h hit2=%b d2=%h, required hit1=%b d1=%h hit2=0 d2=0",
                     bypass_hit1, bypass_data1, bypass_hit2, bypass_data2, BP, BP ? 32'h22 : 32'h0);
        end
        register_source2 = 5'd3;
        #1;
        vectors++;
        if (bypass_hit2 !== BP || bypass_data2 !== (BP ? 32'h33 : 32'h0)) begin
            miscompares++;
            $display("FAIL bypass_src2: hit2=%b d2=%h, required %b %h", bypass_hit2, bypass_data2, BP, BP ? 32'h33 : 32'h0);
        end
        register_source1 = 5'd9;
        #1;
        vectors++;
        if (bypass_hit1 !== 1'b0 || bypass_data1 !== 32'h0) begin
            miscompares++;
            $display("FAIL bypass_miss: hit1=%b d1=%h, required 0 0", bypass_hit1, bypass_data1);
        end
        register_source1 = 5'd7;
        step(0, 0, 0, 0, 0);
        vectors++;
        if (write_enabled !== 1'b1 || register_destiny !== 5'd7 || write_data !== 32'h11
            || bypass_hit1 !== BP || bypass_data1 !== (BP ? 32'h22 : 32'h0)) begin
            miscompares++;
            $display("FAIL bypass_head1: we=%b dst=%0d data=%h hit1=%b d1=%h, required we=1 dst=7 data=11 hit1=%b d1=%h",
                     write_enabled, register_destiny, write_data, bypass_hit1, bypass_data1, BP, BP ? 32'h22 : 32'h0);
        end
        step(0, 0, 0, 0, 0);
        vectors++;
        if (write_data !== 32'h22 || bypass_hit1 !== BP || bypass_data1 !== (BP ? 32'h22 : 32'h0)) begin
            miscompares++;
            $display("FAIL bypass_head2: data=%h hit1=%b d1=%h, required data=22 hit1=%b d1=%h",
                     write_data, bypass_hit1, bypass_data1, BP, BP ? 32'h22 : 32'h0);
        end
        step(0, 0, 0, 0, 0);
        vectors++;
        if (write_data !== 32'h33 || bypass_hit1 !== 1'b0 || bypass_hit2 !== BP) begin
            miscompares++;
            $display("FAIL bypass_head3: data=%h hit1=%b hit2=%b, required data=33 hit1=0 hit2=%b",
                     write_data, bypass_hit1, bypass_hit2, BP);
        end
        step(0, 0, 0, 0, 0);
        vectors++;
        if (pending_count !== 3'd0 || bypass_hit2 !== 1'b0 || bypass_data2 !== 32'h0) begin
            miscompares++;
            $display("FAIL bypass_empty: cnt=%0d hit2=%b d2=%h, required 0 0 0", pending_count, bypass_hit2, bypass_data2);
        end
        register_source1 = 5'd0;
        register_source2 = 5'd0;
    endtask

    task automatic test_flush();
        step(1, 1, 32'hA1, 1, 0);
        step(1, 2, 32'hA2, 1, 0);
        step(1, 3, 32'hA3, 1, 0);
        step(1, 4, 32'hA4, 0, 1);
        vectors++;
        if (pending_count !== 3'd3 || write_enabled !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_cycle: cnt=%0d we=%b, required cnt=3 we=0", pending_count, write_enabled);
        end
        step(0, 0, 0, 0, 0);
        vectors++;
        if (pending_count !== 3'd0 || write_enabled !== 1'b0 || result_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_after: cnt=%0d we=%b rdy=%b, required 0 0 1", pending_count, write_enabled, result_ready);
        end
        step(0, 0, 0, 0, 0);
        vectors++;
        if (write_enabled !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_nowrite: we=%b, required 0", write_enabled);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i <= 4; i++) begin
            step(i < 4, 5'(10 + i), 32'h200 + 32'(i), 0, 0);
            if (i > 0) begin
                vectors++;
                if (write_enabled !== 1'b1 || register_destiny !== 5'(9 + i) || write_data !== 32'h1FF + 32'(i) || pending_count !== 3'd1) begin
                    miscompares++;
                    $display("FAIL b2b%0d: we=%b dst=%0d data=%h cnt=%0d, required we=1 dst=%0d data=%h cnt=1",
                             i, write_enabled, register_destiny, write_data, pending_count, 9 + i, 32'h1FF + 32'(i));
                end
            end
        end
        step(0, 0, 0, 0, 0);
        vectors++;
        if (pending_count !== 3'd0 || write_enabled !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_done: cnt=%0d we=%b, required 0 0", pending_count, write_enabled);
        end
    endtask

    task automatic test_async_reset();
        step(1, 20, 32'hB0, 1, 0);
        step(1, 21, 32'hB1, 1, 0);
        step(0, 0, 0, 1, 0);
        vectors++;
        if (pending_count !== 3'd2) begin
            miscompares++;
            $display("FAIL areset_pre: cnt=%0d, required 2", pending_count);
        end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (pending_count !== 3'd0 || write_enabled !== 1'b0 || register_destiny !== 5'd0 || write_data !== 32'd0 || result_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL areset_now: cnt=%0d we=%b dst=%0d data=%h rdy=%b, required 0 0 0 0 1",
                     pending_count, write_enabled, register_destiny, write_data, result_ready);
        end
        step(0, 0, 0, 0, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0);
            vectors++;
            if (write_enabled !== 1'b0 || pending_count !== 3'd0) begin
                miscompares++;
                $display("FAIL areset_post%0d: we=%b cnt=%0d, required 0 0", i, write_enabled, pending_count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_zero_destiny();
        test_bypass();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
